conv1x1_feeder: RTL and testbench

CONV1X1_FEEDER -- requirements
Module: conv1x1_feeder

---
 rtl/conv1x1_feeder.sv | 124 ++++++++++++
 tb/tb_conv1x1_feeder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/conv1x1_feeder.sv
// Streams image/kernel beats to a 1x1 conv engine and collects one result per pixel.
// Optional macro CONV1X1_FEEDER_RELU_EN clamps negative results to zero.
module conv1x1_feeder #(
  parameter int datwidth     = 16,
  parameter int inputchannel = 64,
  parameter int inputsize    = 55,
  localparam int G   = inputchannel / 16,
  localparam int P   = inputsize * inputsize,
  localparam int IAW = (P * G > 1) ? $clog2(P * G) : 1,
  localparam int KAW = (G > 1) ? $clog2(G) : 1,
  localparam int RAW = (P > 1) ? $clog2(P) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [IAW-1:0]           img_addr,
  input  logic [16*datwidth-1:0]   img_rd_data,
  output logic [KAW-1:0]           ker_addr,
  input  logic [16*datwidth-1:0]   ker_rd_data,
  input  logic [datwidth-1:0]      bias_in,
  output logic [16*datwidth-1:0]   o_imgdata,
  output logic [16*datwidth-1:0]   o_kernel,
  output logic [datwidth-1:0]      o_bias,
  output logic                     o_firstvalue,
  output logic                     o_data_valid,
  input  logic [datwidth-1:0]      i_convolved_data,
  input  logic                     i_convolved_data_valid,
  output logic [datwidth-1:0]      res_data,
  output logic [RAW-1:0]           res_addr,
  output logic                     res_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [KAW-1:0]       ret_g;
  logic [RAW-1:0]       ret_pix;
  logic                 last_issue;
  logic                 ret_beat;
  logic                 last_result;
  logic [datwidth-1:0]  res_val;

  assign last_issue  = (state == RUN) && (img_addr == IAW'(P * G - 1));
  assign ret_beat    = i_convolved_data_valid && (state != IDLE) && (ret_g == KAW'(G - 1));
  assign last_result = ret_beat && (ret_pix == RAW'(P - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_result) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Read issue: img_addr walks linearly, which equals pix*G + g.
  always_ff @(posedge clk) begin
    if (rst) begin
      img_addr     <= '0;
      ker_addr     <= '0;
      o_data_valid <= 1'b0;
      o_firstvalue <= 1'b0;
    end else begin
      o_data_valid <= (state == RUN);
      o_firstvalue <= (state == RUN) && (ker_addr == '0);
      if (state == RUN) begin
        img_addr <= last_issue ? '0 : img_addr + IAW'(1);
        ker_addr <= (ker_addr == KAW'(G - 1)) ? '0 : ker_addr + KAW'(1);
      end
    end
  end

  // Memory data arrives one cycle after the address, aligned with o_data_valid.
  assign o_imgdata = o_data_valid ? img_rd_data : '0;
  assign o_kernel  = o_data_valid ? ker_rd_data : '0;
  assign o_bias    = bias_in;

`ifdef CONV1X1_FEEDER_RELU_EN
  assign res_val = i_convolved_data[datwidth-1] ? '0 : i_convolved_data;
`else
  assign res_val = i_convolved_data;
`endif

  // Returns are counted, not timed, so any engine latency works.
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_g     <= '0;
      ret_pix   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_addr  <= '0;
      done      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      if (state == IDLE) begin
        ret_g   <= '0;
        ret_pix <= '0;
      end else if (i_convolved_data_valid) begin
        ret_g <= (ret_g == KAW'(G - 1)) ? '0 : ret_g + KAW'(1);
        if (ret_beat) begin
          res_valid <= 1'b1;
          res_data  <= res_val;
          res_addr  <= ret_pix;
          ret_pix   <= last_result ? '0 : ret_pix + RAW'(1);
          done      <= last_result && (state == DRAIN);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv1x1_feeder.sv
// Directed bench for conv1x1_feeder with G=2, P=4 and a latency-programmable engine model.
module tb_conv1x1_feeder;
  localparam int IAW = 3;
  localparam int RAW = 2;

  logic           clk = 1'b0;
  logic           rst, start;
  logic           busy, done;
  logic [IAW-1:0] img_addr;
  logic [255:0]   img_rd_data, ker_rd_data, o_imgdata, o_kernel;
  logic [0:0]     ker_addr;
  logic [15:0]    bias_in, o_bias, i_convolved_data, res_data;
  logic           o_firstvalue, o_data_valid, i_convolved_data_valid, res_valid;
  logic [RAW-1:0] res_addr;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int lat = 3;
  bit use_ovr = 1'b0;
  int eidx = 0;
  logic [15:0] vsh = '0;
  int rd_cnt = 0, res_cnt = 0, done_cnt = 0, done_alone = 0, done_cyc = 0;
  logic [15:0]    rlog_d [0:63];
  logic [RAW-1:0] rlog_a [0:63];
  int d3 = 0;

  conv1x1_feeder #(.datwidth(16), .inputchannel(32), .inputsize(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .img_addr(img_addr), .img_rd_data(img_rd_data),
    .ker_addr(ker_addr), .ker_rd_data(ker_rd_data),
    .bias_in(bias_in), .o_imgdata(o_imgdata), .o_kernel(o_kernel), .o_bias(o_bias),
    .o_firstvalue(o_firstvalue), .o_data_valid(o_data_valid),
    .i_convolved_data(i_convolved_data), .i_convolved_data_valid(i_convolved_data_valid),
    .res_data(res_data), .res_addr(res_addr), .res_valid(res_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories: one-cycle read latency, image word = addr+1 in every lane, kernel = 1.
  wire [15:0] img_word = 16'(img_addr) + 16'd1;
  always @(posedge clk) begin
    img_rd_data <= {16{img_word}};
    ker_rd_data <= {16{16'd1}};
  end

  // Engine: echoes o_data_valid after lat cycles with running sums 10,20,...,80.
  always @(posedge clk) begin
    vsh <= {vsh[14:0], o_data_valid};
    if (start && !busy)              eidx <= 0;
    else if (i_convolved_data_valid) eidx <= eidx + 1;
  end
  assign i_convolved_data_valid = vsh[lat-1];
  assign i_convolved_data = (use_ovr && eidx == 7) ? 16'hFFF0 : 16'((eidx + 1) * 10);

  always @(negedge clk) begin
    if (o_data_valid) rd_cnt++;
    if (res_valid) begin
      if (res_cnt < 64) begin rlog_d[res_cnt] = res_data; rlog_a[res_cnt] = res_addr; end
      res_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (!res_valid) done_alone++;
    end
  end

  task automatic pulse_start(output int sc);
    start = 1'b1; sc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; bias_in = 16'h1234;
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_chk++; if (img_addr !== 3'd0) $display("FAIL reset_img_addr: got %0d want 0", img_addr); else n_pass++;
    n_chk++; if (ker_addr !== 1'b0) $display("FAIL reset_ker_addr: got %0d want 0", ker_addr); else n_pass++;
    n_chk++; if (o_data_valid !== 1'b0 || o_firstvalue !== 1'b0) $display("FAIL reset_valid: got %b%b want 00", o_data_valid, o_firstvalue); else n_pass++;
    n_chk++; if (res_valid !== 1'b0 || res_data !== 16'd0 || res_addr !== 2'd0) $display("FAIL reset_res: got %b %h %0d want 0 0 0", res_valid, res_data, res_addr); else n_pass++;
    n_chk++; if (o_imgdata !== 256'd0 || o_kernel !== 256'd0) $display("FAIL reset_data: got %h %h want 0", o_imgdata[15:0], o_kernel[15:0]); else n_pass++;
    n_chk++; if (o_bias !== 16'h1234) $display("FAIL bias_pass: got %h want 1234", o_bias); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_run;
    int sc, rb, db;
    bit ok;
    logic [255:0] exp_img;
    rb = res_cnt; db = done_cnt;
    pulse_start(sc);
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        n_chk++; if (img_addr !== 3'(i)) $display("FAIL run_img_addr%0d: got %0d want %0d", i, img_addr, i); else n_pass++;
        n_chk++; if (ker_addr !== 1'(i % 2)) $display("FAIL run_ker_addr%0d: got %0d want %0d", i, ker_addr, i % 2); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL run_busy%0d: got %b want 1", i, busy); else n_pass++;
      end
      if (i == 0) begin
        n_chk++; if (o_data_valid !== 1'b0) $display("FAIL run_first_valid: got %b want 0", o_data_valid); else n_pass++;
      end else begin
        exp_img = {16{16'(i)}};
        n_chk++; if (o_data_valid !== 1'b1) $display("FAIL run_valid%0d: got %b want 1", i, o_data_valid); else n_pass++;
        n_chk++; if (o_firstvalue !== ((i - 1) % 2 == 0)) $display("FAIL run_firstvalue%0d: got %b want %b", i, o_firstvalue, (i - 1) % 2 == 0); else n_pass++;
        n_chk++; if (o_imgdata !== exp_img) $display("FAIL run_imgdata%0d: got %h want %h", i, o_imgdata[15:0], exp_img[15:0]); else n_pass++;
        n_chk++; if (o_kernel !== {16{16'd1}}) $display("FAIL run_kernel%0d: got %h want 1", i, o_kernel[15:0]); else n_pass++;
      end
      @(negedge clk);
    end
    wait_done(60, ok);
    n_chk++; if (!ok) $display("FAIL run_done_timeout: got no done want done"); else n_pass++;
    n_chk++; if (res_cnt - rb !== 4) $display("FAIL run_res_count: got %0d want 4", res_cnt - rb); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (rlog_d[rb + k] !== 16'((k + 1) * 20)) $display("FAIL run_res_data%0d: got %0d want %0d", k, rlog_d[rb + k], (k + 1) * 20); else n_pass++;
      n_chk++; if (rlog_a[rb + k] !== 2'(k)) $display("FAIL run_res_addr%0d: got %0d want %0d", k, rlog_a[rb + k], k); else n_pass++;
    end
    n_chk++; if (done_cnt - db !== 1 || done_alone !== 0) $display("FAIL run_done_pulse: got %0d lone %0d want 1 lone 0", done_cnt - db, done_alone); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL run_busy_after: got %b want 0", busy); else n_pass++;
    d3 = done_cyc - sc;
  endtask

  task automatic test_restart_ignored;
    int sc, rb, db, rdb;
    bit ok;
    rb = res_cnt; db = done_cnt; rdb = rd_cnt;
    pulse_start(sc);
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(60, ok);
    repeat (10) @(negedge clk);
    n_chk++; if (!ok) $display("FAIL restart_done_timeout: got no done want done"); else n_pass++;
    n_chk++; if (rd_cnt - rdb !== 8) $display("FAIL restart_reads: got %0d want 8", rd_cnt - rdb); else n_pass++;
    n_chk++; if (done_cnt - db !== 1) $display("FAIL restart_dones: got %0d want 1", done_cnt - db); else n_pass++;
    n_chk++; if (res_cnt - rb !== 4) $display("FAIL restart_results: got %0d want 4", res_cnt - rb); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL restart_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_midrun;
    int sc, rb, db;
    bit ok;
    rb = res_cnt; db = done_cnt;
    pulse_start(sc);
    repeat (4) @(negedge clk);
    n_chk++; if (img_addr !== 3'd4) $display("FAIL abort_fifth_read: got %0d want 4", img_addr); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_busy_done: got %b%b want 00", busy, done); else n_pass++;
    n_chk++; if (img_addr !== 3'd0 || ker_addr !== 1'b0) $display("FAIL abort_addr: got %0d %0d want 0 0", img_addr, ker_addr); else n_pass++;
    n_chk++; if (o_data_valid !== 1'b0 || o_firstvalue !== 1'b0 || o_imgdata !== 256'd0 || o_kernel !== 256'd0) $display("FAIL abort_stream: got %b%b want 00", o_data_valid, o_firstvalue); else n_pass++;
    n_chk++; if (res_valid !== 1'b0 || res_data !== 16'd0 || res_addr !== 2'd0) $display("FAIL abort_res: got %b %h %0d want 0 0 0", res_valid, res_data, res_addr); else n_pass++;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    n_chk++; if (res_cnt - rb !== 0 || done_cnt - db !== 0) $display("FAIL abort_no_output: got res %0d done %0d want 0 0", res_cnt - rb, done_cnt - db); else n_pass++;
    pulse_start(sc);
    n_chk++; if (img_addr !== 3'd0 || busy !== 1'b1) $display("FAIL abort_restart_addr: got %0d busy %b want 0 1", img_addr, busy); else n_pass++;
    wait_done(60, ok);
    n_chk++; if (!ok) $display("FAIL abort_rerun_timeout: got no done want done"); else n_pass++;
    n_chk++; if (res_cnt - rb !== 4) $display("FAIL abort_rerun_count: got %0d want 4", res_cnt - rb); else n_pass++;
    n_chk++; if (rlog_d[rb] !== 16'd20 || rlog_a[rb] !== 2'd0) $display("FAIL abort_rerun_first: got %0d @%0d want 20 @0", rlog_d[rb], rlog_a[rb]); else n_pass++;
  endtask

  task automatic test_relu;
    int sc, rb;
    bit ok;
    logic [15:0] exp_last;
`ifdef CONV1X1_FEEDER_RELU_EN
    exp_last = 16'h0000;
`else
    exp_last = 16'hFFF0;
`endif
    rb = res_cnt; use_ovr = 1'b1;
    pulse_start(sc);
    wait_done(60, ok);
    use_ovr = 1'b0;
    n_chk++; if (!ok) $display("FAIL relu_done_timeout: got no done want done"); else n_pass++;
    n_chk++; if (rlog_d[rb + 2] !== 16'd60) $display("FAIL relu_positive: got %0d want 60", rlog_d[rb + 2]); else n_pass++;
    n_chk++; if (rlog_d[rb + 3] !== exp_last) $display("FAIL relu_final: got %h want %h", rlog_d[rb + 3], exp_last); else n_pass++;
  endtask

  task automatic test_latency;
    int sc, rb;
    bit ok;
    rb = res_cnt; lat = 6;
    pulse_start(sc);
    wait_done(80, ok);
    n_chk++; if (!ok) $display("FAIL lat6_done_timeout: got no done want done"); else n_pass++;
    n_chk++; if (res_cnt - rb !== 4) $display("FAIL lat6_count: got %0d want 4", res_cnt - rb); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (rlog_d[rb + k] !== 16'((k + 1) * 20) || rlog_a[rb + k] !== 2'(k)) $display("FAIL lat6_res%0d: got %0d @%0d want %0d @%0d", k, rlog_d[rb + k], rlog_a[rb + k], (k + 1) * 20, k); else n_pass++;
    end
    n_chk++; if (done_cyc - sc !== d3 + 3) $display("FAIL lat6_done_delay: got %0d want %0d", done_cyc - sc, d3 + 3); else n_pass++;
    lat = 3;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bias_in = 16'h1234;
    test_reset();
    test_run();
    test_restart_ignored();
    test_reset_midrun();
    test_relu();
    test_latency();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
